// File: rtl/usart_rx_ctrl.sv
// Receive-side controller for the 16x-oversampling USART: synchronises receiver flags,
// runs the acknowledge handshake, and buffers bytes in a show-ahead FIFO with error counters.
module usart_rx_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            rx_data,
  input  logic                  rx_available,
  input  logic                  rx_error,
  output logic                  rx_acknowledge,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            overrun_count,
  output logic [7:0]            frame_error_count,
  input  logic                  clear_counts,
  output logic                  irq
);

  localparam int                   DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  DEPTH_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  CNT_ONE     = (DEPTH_LOG2+1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic                   avail_meta, avail_s, err_meta, err_s;
  logic                   ack_next, capture;
  logic                   pop, push, frame_inc, overrun_inc;
  logic [DEPTH_LOG2-1:0]  rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [DEPTH_LOG2:0]    count_next;
  logic [7:0]             head_next, overrun_next, frame_next;
  logic [7:0]             mem [DEPTH];

  // Handshake sequencer: next state and acknowledge level
  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (avail_s || err_s)) begin
          state_next = CAPTURE;
        end else begin
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        ack_next   = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        if (!avail_s && !err_s) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end else begin
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FIFO and counter next-state; a pop in the capture cycle frees the slot for the push
  always_comb begin
    pop         = rd_en && !empty;
    push        = capture && !err_s && (!full || pop);
    frame_inc   = capture && err_s;
    overrun_inc = capture && !err_s && full && !pop;
    rd_ptr_next = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    wr_ptr_next = push ? wr_ptr + PTR_ONE : wr_ptr;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
    if (count_next == {(DEPTH_LOG2+1){1'b0}}) begin
      head_next = 8'h00;
    end else if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = rx_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
    if (clear_counts) begin
      overrun_next = 8'h00;
      frame_next   = 8'h00;
    end else begin
      overrun_next = (overrun_inc && overrun_count != 8'hFF) ? overrun_count + 8'h01 : overrun_count;
      frame_next   = (frame_inc && frame_error_count != 8'hFF) ? frame_error_count + 8'h01 : frame_error_count;
    end
  end

  // Control, synchroniser and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      avail_meta        <= 1'b0;
      avail_s           <= 1'b0;
      err_meta          <= 1'b0;
      err_s             <= 1'b0;
      rx_acknowledge    <= 1'b0;
      rd_ptr            <= {DEPTH_LOG2{1'b0}};
      wr_ptr            <= {DEPTH_LOG2{1'b0}};
      count             <= {(DEPTH_LOG2+1){1'b0}};
      empty             <= 1'b1;
      full              <= 1'b0;
      rd_data           <= 8'h00;
      irq               <= 1'b0;
      overrun_count     <= 8'h00;
      frame_error_count <= 8'h00;
    end else begin
      state             <= state_next;
      avail_meta        <= rx_available;
      avail_s           <= avail_meta;
      err_meta          <= rx_error;
      err_s             <= err_meta;
      rx_acknowledge    <= ack_next;
      rd_ptr            <= rd_ptr_next;
      wr_ptr            <= wr_ptr_next;
      count             <= count_next;
      empty             <= (count_next == {(DEPTH_LOG2+1){1'b0}});
      full              <= (count_next == DEPTH_COUNT);
      rd_data           <= head_next;
      irq               <= (count_next != {(DEPTH_LOG2+1){1'b0}});
      overrun_count     <= overrun_next;
      frame_error_count <= frame_next;
    end
  end

  // Storage array; contents are only observed through the pointer-guarded head register
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

endmodule

// File: tb/tb_usart_rx_ctrl.sv
// Directed self-checking bench for usart_rx_ctrl: latency, fill/overrun, framing errors,
// full-with-pop, counter saturation/clear and asynchronous reset in the middle of a handshake.
module tb_usart_rx_ctrl;
  logic       clock = 1'b0;
  logic       reset, enable, rx_available, rx_error, rd_en, clear_counts;
  logic [7:0] rx_data;
  logic       rx_acknowledge, empty, full, irq;
  logic [7:0] rd_data, overrun_count, frame_error_count;
  logic [3:0] count;
  int         compared = 0;
  int         mismatched = 0;

  usart_rx_ctrl #(.DEPTH_LOG2(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx_data(rx_data),
    .rx_available(rx_available), .rx_error(rx_error), .rx_acknowledge(rx_acknowledge),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun_count(overrun_count), .frame_error_count(frame_error_count),
    .clear_counts(clear_counts), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (rx_acknowledge !== lvl && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(rx_acknowledge), 32'(lvl));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic err);
    rx_data      = d;
    rx_available = 1'b1;
    rx_error     = err;
    wait_ack(1'b1, "ack_rise");
    rx_available = 1'b0;
    rx_error     = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic pop_check(input logic [7:0] exp);
    check("pop_data", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rx_available = 1'b0; rx_error = 1'b0;
    rd_en = 1'b0; clear_counts = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ack", 32'(rx_acknowledge), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_ovr", 32'(overrun_count), 32'd0);
    check("rst_fec", 32'(frame_error_count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    enable = 1'b1;

    // Single byte with exact latency
    rx_data = 8'hA5; rx_available = 1'b1;
    repeat (3) @(negedge clock);
    check("lat_ack_early", 32'(rx_acknowledge), 32'd0);
    @(negedge clock);
    check("lat_ack", 32'(rx_acknowledge), 32'd1);
    check("single_count", 32'(count), 32'd1);
    check("single_data", 32'(rd_data), 32'hA5);
    check("single_irq", 32'(irq), 32'd1);
    rx_available = 1'b0;
    repeat (2) @(negedge clock);
    check("ack_hold", 32'(rx_acknowledge), 32'd1);
    @(negedge clock);
    check("ack_release", 32'(rx_acknowledge), 32'd0);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_irq", 32'(irq), 32'd0);
    check("pop_rd_data", 32'(rd_data), 32'h00);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    check("rd_empty_ignored", 32'(count), 32'd0);

    // Event held pending while disabled
    enable = 1'b0; rx_data = 8'hC3; rx_available = 1'b1;
    repeat (6) @(negedge clock);
    check("disabled_no_ack", 32'(rx_acknowledge), 32'd0);
    enable = 1'b1;
    wait_ack(1'b1, "enable_ack");
    rx_available = 1'b0;
    wait_ack(1'b0, "enable_ack_fall");
    check("enable_data", 32'(rd_data), 32'hC3);
    pop_check(8'hC3);

    // Fill and overrun
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    send_byte(8'h09, 1'b0);
    check("ovr_count", 32'(overrun_count), 32'd1);
    check("ovr_fifo_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) pop_check(8'(i));
    check("drain_empty", 32'(empty), 32'd1);

    // Framing error with both flags set
    send_byte(8'hEE, 1'b1);
    check("fe_count", 32'(frame_error_count), 32'd1);
    check("fe_no_push", 32'(count), 32'd0);

    // Full FIFO plus pop in the capture cycle
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
    rx_data = 8'h55; rx_available = 1'b1;
    repeat (3) @(negedge clock);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    check("fullpop_ack", 32'(rx_acknowledge), 32'd1);
    check("fullpop_count", 32'(count), 32'd8);
    check("fullpop_ovr", 32'(overrun_count), 32'd1);
    rx_available = 1'b0;
    wait_ack(1'b0, "fullpop_ack_fall");
    for (int i = 1; i < 8; i++) pop_check(8'h10 + 8'(i));
    pop_check(8'h55);
    check("fullpop_empty", 32'(empty), 32'd1);

    // Saturation: 255 more errors makes 256 in total
    for (int i = 0; i < 255; i++) send_byte(8'h00, 1'b1);
    check("fe_saturated", 32'(frame_error_count), 32'hFF);
    rx_available = 1'b1; rx_error = 1'b1;
    repeat (3) @(negedge clock);
    clear_counts = 1'b1;
    @(negedge clock);
    clear_counts = 1'b0;
    check("clear_ack", 32'(rx_acknowledge), 32'd1);
    check("clear_fec", 32'(frame_error_count), 32'd0);
    check("clear_ovr", 32'(overrun_count), 32'd0);
    rx_available = 1'b0; rx_error = 1'b0;
    wait_ack(1'b0, "clear_ack_fall");

    // Asynchronous reset while in ACK with three entries stored
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    rx_data = 8'h33; rx_available = 1'b1;
    wait_ack(1'b1, "pre_reset_ack");
    check("pre_reset_count", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async_ack", 32'(rx_acknowledge), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    rx_data = 8'h77;
    @(negedge clock);
    reset = 1'b0;
    wait_ack(1'b1, "post_reset_ack");
    rx_available = 1'b0;
    wait_ack(1'b0, "post_reset_ack_fall");
    repeat (3) @(negedge clock);
    check("post_reset_count", 32'(count), 32'd1);
    check("post_reset_data", 32'(rd_data), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/usart_rx_ctrl.md
Name: usart_rx_ctrl

Overview:
Receive-side controller that sequences the acknowledge handshake of the 16x-oversampling USART receiver and buffers received bytes in a small FIFO for a CPU or bus master. It runs on the system clock, which is asynchronous to the receiver's bit_clock_x16 domain. It synchronises the receiver's available/error flags, captures each byte, and drives rx_acknowledge. It also keeps saturating overrun and framing-error counters and exposes a show-ahead read port with an interrupt.

Parameters:
DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 entries (8 by default); legal range 1..6.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
enable  input  1  when 0, the FSM does not leave IDLE and receiver events stay pending.
rx_data  input  8  byte from the receiver; valid while rx_available is high.
rx_available  input  1  receiver "byte ready" flag (bit_clock domain).
rx_error  input  1  receiver framing-error flag (bit_clock domain).
rx_acknowledge  output  1  level acknowledge to the receiver; registered.
rd_en  input  1  pop request for the FIFO head.
rd_data  output  8  FIFO head entry (show-ahead); 8'h00 when empty.
empty  output  1  FIFO empty.
full  output  1  FIFO full.
count  output  DEPTH_LOG2+1  number of occupied entries.
overrun_count  output  8  bytes dropped because the FIFO was full; saturates at 255.
frame_error_count  output  8  framing errors seen; saturates at 255.
clear_counts  input  1  synchronous clear of both counters.
irq  output  1  registered copy of !empty.

Behaviour:
- Reset values: rx_acknowledge=0, empty=1, full=0, count=0, rd_data=8'h00, overrun_count=0, frame_error_count=0, irq=0, FSM=IDLE, sync flops=0, FIFO pointers=0.
- rx_available and rx_error each pass through a 2-flop synchroniser (avail_s, err_s). rx_data is sampled unsynchronised, only in CAPTURE; the receiver holds data_out stable until it is acknowledged.
- FSM states: IDLE, CAPTURE, ACK.
  - IDLE: if enable and (avail_s or err_s), go to CAPTURE; otherwise stay.
  - CAPTURE (1 cycle):
    - err_s=1 (including err_s and avail_s both 1): frame_error_count increments (saturating); no push.
    - Else if the FIFO is not full, or a pop happens in the same cycle: push rx_data.
    - Else: overrun_count increments (saturating) and the byte is discarded.
    - Always set rx_acknowledge=1 and go to ACK.
  - ACK: hold rx_acknowledge=1 until avail_s=0 and err_s=0; on that edge set rx_acknowledge=0 and go to IDLE. enable has no effect once the FSM has left IDLE.
- Latency: rx_available rises before edge 0 -> avail_s=1 after edge 1 -> CAPTURE after edge 2 -> FIFO written and rx_acknowledge=1 after edge 3. rx_available falls -> rx_acknowledge=0 three edges later.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read and write pointers; pointers wrap modulo depth.
  - count runs 0..2**DEPTH_LOG2; full=(count==depth); empty=(count==0).
  - A pop occurs when rd_en=1 and empty=0. rd_en while empty is ignored: no pointer move, no error.
  - Simultaneous push and pop: both pointers advance and count is unchanged, including when full (the push is accepted) and when count=1.
  - rd_data always shows the head entry; it updates on the edge after a pop or after a push into an empty FIFO.
- Counters: clear_counts=1 zeroes both counters on the next edge and takes priority over an increment in the same cycle.
- irq is registered from the next-state empty and falls one edge after the last pop.
- Reset mid-operation, in any state: everything returns to reset values and rx_acknowledge drops asynchronously. A receiver flag still high after reset release is processed as a new event.

Test Plan:
- Single byte: pulse rx_available with rx_data=8'hA5 until rx_acknowledge -> rx_acknowledge=1 at edge 3, count=1, rd_data=8'hA5, irq=1; after rd_en for 1 cycle -> empty=1, irq=0 one edge later.
- Fill and overrun, depth 8: send bytes 8'h01..8'h09 -> full=1 after the 8th byte; the 9th is acknowledged but dropped, overrun_count=1; popping all 8 yields 8'h01..8'h08 in order.
- Framing error: rx_error=1 with rx_available=1 -> frame_error_count=1, count unchanged, rx_acknowledge asserted then released after both flags drop.
- Full plus simultaneous pop: with FIFO full, assert rd_en in the CAPTURE cycle of byte 8'h55 -> count stays 8, overrun_count unchanged, 8'h55 is the last entry read.
- Counter saturation and clear: 256 framing errors -> frame_error_count=255 held; clear_counts together with a 257th error -> count=0.
- Async reset while in ACK with 3 entries stored -> rx_acknowledge=0 immediately, count=0, empty=1; with rx_available still high after release, the byte is captured once.
